bits_unpacker: RTL and testbench



---
 rtl/bits_pkg.sv | 24 ++
 rtl/bits_word_fifo.sv | 55 +++++
 rtl/bits_unpacker.sv | 103 ++++++++++
 tb/tb_bits_unpacker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bits_pkg.sv
// Shared defaults and width helpers for the bits_unpacker slice.
package bits_pkg;

  localparam int unsigned DEF_DIN_W  = 32;
  localparam int unsigned DEF_DOUT_W = 15;
  localparam int unsigned DEF_LEN_W  = 4;
  localparam int unsigned DEF_DEPTH  = 8;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    longint unsigned span;
    result = 0;
    span   = 1;
    while (span < longint'(value)) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  localparam int unsigned DEF_AVAIL_W = clog2(2 * DEF_DIN_W + 1);

endpackage

// File: rtl/bits_word_fifo.sv
// Synchronous DEPTH x W word FIFO with registered full/empty flags.
module bits_word_fifo
  import bits_pkg::*;
#(
  parameter int unsigned W     = DEF_DIN_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign dout       = mem[rd_ptr];

  // Flags are computed from the next count so they track the count register exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bits_unpacker.sv
// Word-in, variable-length-field-out bit-stream unpacker (MSB-first).
// Define BITS_UNPACKER_ERR_EN to enable the sticky overflow/underflow flag on errout.
module bits_unpacker
  import bits_pkg::*;
#(
  parameter int unsigned DIN_W  = DEF_DIN_W,
  parameter int unsigned DOUT_W = DEF_DOUT_W,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pushin,
  input  logic [DIN_W-1:0]  datain,
  output logic              fullout,
  input  logic              reqin,
  input  logic [LEN_W-1:0]  reqlen,
  output logic              readyout,
  output logic              pushout,
  output logic [LEN_W-1:0]  lenout,
  output logic [DOUT_W-1:0] dataout,
  output logic              errout
);

  localparam int unsigned ACC_W   = 2 * DIN_W;
  localparam int unsigned AVAIL_W = clog2(ACC_W + 1);

  logic [ACC_W-1:0]   acc;
  logic [AVAIL_W-1:0] avail;

  logic [DIN_W-1:0]   fifo_dout;
  logic               fifo_empty;
  logic               refill;

  logic [LEN_W-1:0]   len_sat;
  logic [AVAIL_W-1:0] take_len;
  logic [AVAIL_W-1:0] take;
  logic [AVAIL_W-1:0] rem;
  logic               accept;
  logic [ACC_W-1:0]   field_full;
  logic [ACC_W-1:0]   acc_next;
  logic [AVAIL_W-1:0] avail_next;

  bits_word_fifo #(
    .W     (DIN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (pushin),
    .din   (datain),
    .pop   (refill),
    .dout  (fifo_dout),
    .full  (fullout),
    .empty (fifo_empty)
  );

  // Valid bits sit left-justified in acc; bits below avail are kept zero.
  assign len_sat    = (reqlen > LEN_W'(DOUT_W)) ? LEN_W'(DOUT_W) : reqlen;
  assign take_len   = AVAIL_W'(len_sat);
  assign readyout   = (avail >= take_len);
  assign accept     = reqin && readyout;
  assign take       = accept ? take_len : '0;
  assign rem        = avail - take;
  assign refill     = !fifo_empty && (rem <= AVAIL_W'(DIN_W));
  assign field_full = acc >> (AVAIL_W'(ACC_W) - take);

  // New word lands directly beneath whatever survives this cycle's extraction.
  assign acc_next   = refill ? ((acc << take) | ({fifo_dout, {DIN_W{1'b0}}} >> rem))
                             : (acc << take);
  assign avail_next = rem + (refill ? AVAIL_W'(DIN_W) : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc     <= '0;
      avail   <= '0;
      pushout <= 1'b0;
      lenout  <= '0;
      dataout <= '0;
    end else begin
      acc     <= acc_next;
      avail   <= avail_next;
      pushout <= accept;
      if (accept) begin
        lenout  <= len_sat;
        dataout <= DOUT_W'(field_full);
      end
    end
  end

`ifdef BITS_UNPACKER_ERR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      errout <= 1'b0;
    end else if ((pushin && fullout) || (reqin && !readyout)) begin
      errout <= 1'b1;
    end
  end
`else
  assign errout = 1'b0;
`endif

endmodule

// File: tb/tb_bits_unpacker.sv
// Self-checking bench for bits_unpacker: directed vector table, corner sequences, random traffic vs queue model.
module tb_bits_unpacker;

  localparam int unsigned DIN_W  = 32;
  localparam int unsigned DOUT_W = 15;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DEPTH  = 8;

`ifdef BITS_UNPACKER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              pushin;
  logic [DIN_W-1:0]  datain;
  logic              fullout;
  logic              reqin;
  logic [LEN_W-1:0]  reqlen;
  logic              readyout;
  logic              pushout;
  logic [LEN_W-1:0]  lenout;
  logic [DOUT_W-1:0] dataout;
  logic              errout;

  bits_unpacker #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W),
    .LEN_W  (LEN_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pushin   (pushin),
    .datain   (datain),
    .fullout  (fullout),
    .reqin    (reqin),
    .reqlen   (reqlen),
    .readyout (readyout),
    .pushout  (pushout),
    .lenout   (lenout),
    .dataout  (dataout),
    .errout   (errout)
  );

  always #5 clock = ~clock;

  int n_tests;
  int n_fail;

  // Reference model: a word queue for the FIFO and a bit queue for the accumulated stream.
  logic [DIN_W-1:0]  m_fifo[$];
  bit                m_bits[$];
  bit                m_full;
  bit                m_err;
  bit                m_push;
  logic [LEN_W-1:0]  m_len;
  logic [DOUT_W-1:0] m_data;

  typedef struct {
    bit                push;
    logic [DIN_W-1:0]  din;
    bit                req;
    logic [LEN_W-1:0]  len;
    bit                e_rdy;
    bit                e_po;
    logic [LEN_W-1:0]  e_len;
    logic [DOUT_W-1:0] e_data;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(bit p, logic [DIN_W-1:0] d, bit r, int l,
                              bit er, bit ep, int el, int ed);
    vec_t v;
    v.push = p; v.din = d; v.req = r; v.len = LEN_W'(l);
    v.e_rdy = er; v.e_po = ep; v.e_len = LEN_W'(el); v.e_data = DOUT_W'(ed);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat_len(input logic [LEN_W-1:0] l);
    return (int'(l) > int'(DOUT_W)) ? int'(DOUT_W) : int'(l);
  endfunction

  function automatic bit model_ready();
    return m_bits.size() >= sat_len(reqlen);
  endfunction

  task automatic model_clear();
    m_fifo.delete();
    m_bits.delete();
    m_full = 0; m_err = 0; m_push = 0; m_len = '0; m_data = '0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  s;
    bit  rdy;
    int  v;
    logic [DIN_W-1:0] w;
    if (reset) begin
      model_clear();
      return;
    end
    s   = sat_len(reqlen);
    rdy = m_bits.size() >= s;
    if (ERR_EN && ((pushin && m_full) || (reqin && !rdy))) m_err = 1;
    m_push = reqin && rdy;
    if (m_push) begin
      v = 0;
      for (int i = 0; i < s; i++) v = (v << 1) | int'(m_bits.pop_front());
      m_len  = LEN_W'(s);
      m_data = DOUT_W'(v);
    end
    if (m_fifo.size() > 0 && m_bits.size() <= int'(DIN_W)) begin
      w = m_fifo.pop_front();
      for (int i = int'(DIN_W) - 1; i >= 0; i--) m_bits.push_back(w[i]);
    end
    if (pushin && !m_full) m_fifo.push_back(datain);
    m_full = (m_fifo.size() == int'(DEPTH));
  endtask

  task automatic drive(input bit p, input logic [DIN_W-1:0] d, input bit r, input int l);
    pushin = p;
    datain = d;
    reqin  = r;
    reqlen = LEN_W'(l);
  endtask

  task automatic cycle(output logic rdy);
    @(negedge clock);
    rdy = readyout;
    check("readyout", 32'(readyout), 32'(model_ready()));
    model_step();
    @(posedge clock);
    #1;
    check("pushout", 32'(pushout), 32'(m_push));
    check("lenout",  32'(lenout),  32'(m_len));
    check("dataout", 32'(dataout), 32'(m_data));
    check("fullout", 32'(fullout), 32'(m_full));
    check("errout",  32'(errout),  32'(m_err));
  endtask

  task automatic reset_cycle();
    logic rdy;
    reset = 1'b1;
    drive(0, '0, 1, 1);
    cycle(rdy);
    reset = 1'b0;
    drive(0, '0, 0, 0);
  endtask

  initial begin
    logic rdy;
    logic [DIN_W-1:0] w;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(0, '0, 0, 0);
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_pushout", 32'(pushout), 32'd0);
    check("rst_lenout",  32'(lenout),  32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);
    check("rst_fullout", 32'(fullout), 32'd0);
    check("rst_errout",  32'(errout),  32'd0);

    // Directed vectors: single word split 4/8/15/stall/5, then a field crossing a word boundary.
    vecs[0]  = mk(1, 32'hA5A50F0F, 0, 0,  1, 0, 0,  'h0);
    vecs[1]  = mk(0, '0,           0, 0,  1, 0, 0,  'h0);
    vecs[2]  = mk(0, '0,           1, 4,  1, 1, 4,  'hA);
    vecs[3]  = mk(0, '0,           1, 8,  1, 1, 8,  'h5A);
    vecs[4]  = mk(0, '0,           1, 15, 1, 1, 15, 'h2878);
    vecs[5]  = mk(0, '0,           1, 6,  0, 0, 15, 'h2878);
    vecs[6]  = mk(0, '0,           1, 5,  1, 1, 5,  'h0F);
    vecs[7]  = mk(1, 32'hFFFFFFFF, 0, 0,  1, 0, 5,  'h0F);
    vecs[8]  = mk(1, 32'h00000000, 0, 0,  1, 0, 5,  'h0F);
    vecs[9]  = mk(0, '0,           0, 0,  1, 0, 5,  'h0F);
    vecs[10] = mk(0, '0,           1, 15, 1, 1, 15, 'h7FFF);
    vecs[11] = mk(0, '0,           1, 15, 1, 1, 15, 'h7FFF);
    vecs[12] = mk(0, '0,           1, 4,  1, 1, 4,  'hC);
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].push, vecs[i].din, vecs[i].req, int'(vecs[i].len));
      cycle(rdy);
      check($sformatf("vec%0d_rdy", i),  32'(rdy),     32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_po", i),   32'(pushout), 32'(vecs[i].e_po));
      check($sformatf("vec%0d_len", i),  32'(lenout),  32'(vecs[i].e_len));
      check($sformatf("vec%0d_data", i), 32'(dataout), 32'(vecs[i].e_data));
    end
    check("vec_err_after_stall", 32'(errout), 32'(ERR_EN));

    // Zero-length request on an empty accumulator, then an underflow.
    reset_cycle();
    drive(0, '0, 1, 0);
    cycle(rdy);
    check("req0_po",   32'(pushout), 32'd1);
    check("req0_len",  32'(lenout),  32'd0);
    check("req0_data", 32'(dataout), 32'd0);
    drive(0, '0, 1, 1);
    cycle(rdy);
    check("req1_rdy", 32'(rdy),     32'd0);
    check("req1_po",  32'(pushout), 32'd0);
    check("req1_err", 32'(errout),  32'(ERR_EN));

    // Overflow: two words drain into the accumulator, so the 10th push fills the FIFO.
    reset_cycle();
    for (int k = 0; k < 11; k++) begin
      drive(1, DIN_W'($urandom), 0, 0);
      cycle(rdy);
      if (k == 8) check("ovf_not_full_k8", 32'(fullout), 32'd0);
      if (k == 9) check("ovf_full_k9",     32'(fullout), 32'd1);
    end
    check("ovf_err", 32'(errout), 32'(ERR_EN));
    for (int k = 0; k < 30; k++) begin
      drive(0, '0, 1, 15);
      cycle(rdy);
    end
    check("ovf_drained_full", 32'(fullout), 32'd0);

    // Continuous push and 15-bit requests every cycle.
    reset_cycle();
    for (int k = 0; k < 64; k++) begin
      drive(1, DIN_W'($urandom), 1, 15);
      cycle(rdy);
    end

    // Mid-stream reset with buffered data; stream restarts from the next word.
    reset_cycle();
    for (int k = 0; k < 5; k++) begin
      drive(1, DIN_W'($urandom), 0, 0);
      cycle(rdy);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, '0, 1, 15);
      cycle(rdy);
    end
    reset = 1'b1;
    drive(1, 32'hDEADBEEF, 1, 7);
    cycle(rdy);
    reset = 1'b0;
    check("mrst_po",   32'(pushout), 32'd0);
    check("mrst_len",  32'(lenout),  32'd0);
    check("mrst_data", 32'(dataout), 32'd0);
    check("mrst_full", 32'(fullout), 32'd0);
    check("mrst_err",  32'(errout),  32'd0);
    drive(0, '0, 1, 1);
    cycle(rdy);
    check("mrst_rdy", 32'(rdy), 32'd0);
    w = 32'h12345678;
    drive(1, w, 0, 0);
    cycle(rdy);
    drive(0, '0, 0, 0);
    cycle(rdy);
    drive(0, '0, 1, 15);
    cycle(rdy);
    check("mrst_restart_data", 32'(dataout), 32'(w[31:17]));

    // Random traffic with occasional resets.
    reset_cycle();
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(63) == 0);
      drive(bit'($urandom_range(1)), DIN_W'($urandom), bit'($urandom_range(1)),
            int'($urandom_range(15)));
      cycle(rdy);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
